mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the IF stage (read-only) and the MEM stage (read/write).
- Sits between the pipeline and the memory. Downstream memory has a fixed read latency of LAT cycles.
- Data side has priority. A starvation guard guarantees fetch progress.
- Requesters stall on req-high-without-ack; the hazard unit consumes busy.

Parameters:
LAT, 1, memory latency in cycles from mem_en-high cycle to mem_rdata valid; legal range 1..15
STARVE_LIM, 4, consecutive contested data grants after which a pending IF request wins; legal range 1..15

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  32  fetch byte address, stable while if_req high
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  32  fetched instruction, registered
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_ack  out  1  one-cycle completion pulse
d_rdata  out  32  read data, registered; unchanged by writes
mem_en  out  1  one-cycle access strobe to memory
mem_we  out  1  write strobe, only with mem_en
mem_addr  out  32  byte address, passed unmodified (no alignment)
mem_wdata  out  32  write data to memory
mem_rdata  in  32  memory read data, valid LAT cycles after mem_en cycle
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; if_ack=d_ack=mem_en=mem_we=busy=0; mem_addr=mem_wdata=if_rdata=d_rdata=0; cnt=0; streak=0.
- FSM states:
  - IDLE: sample reqs. On any req, pick winner, register mem_addr/mem_we/mem_wdata, set mem_en=1, go ISSUE.
  - ISSUE: mem_en high exactly this cycle. cnt=LAT, go WAIT.
  - WAIT: decrement cnt each cycle. When cnt reaches 1: for reads, capture mem_rdata into the winner's rdata; raise the winner's ack; go DONE.
  - DONE: ack high exactly this cycle. Reqs ignored. Go IDLE.
- Timing: request first seen in IDLE at cycle T gives ack in cycle T+LAT+2. Max throughput is one access per LAT+3 cycles.
- Requesters may keep req high through the ack cycle to issue a new access; it is re-sampled in IDLE.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant data unless streak==STARVE_LIM, then grant IF.
  - A data grant while if_req is high increments streak, saturating at STARVE_LIM.
  - Any IF grant clears streak. An uncontested data grant leaves streak unchanged.
- Writes: mem_we=1 with mem_en. d_ack comes after the same LAT wait. d_rdata holds its previous value.
- Address/data are latched at grant. Requester changes after grant have no effect on the in-flight access.
- Reset mid-access: FSM returns to IDLE. No ack is issued for the in-flight access. A write already strobed completes in memory; a pending read is discarded.
- busy=0 only in IDLE.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs if_stall_cnt[31:0] and d_stall_cnt[31:0]. Each increments every cycle its req is high and its ack is low. Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- LAT=2, mem[0x10]=0xDEADBEEF; if_req=1, if_addr=0x40 at T0 -> mem_en at T1 with mem_addr=0x40; if_ack and if_rdata=0xDEADBEEF at T4 only.
- d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678 -> single mem_en/mem_we pulse; d_ack at T4. A following read of 0x100 returns 0x12345678; d_rdata unchanged after the write ack.
- if_req and d_req held continuously, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I; no ack ever overlaps the other requester's ack.
- Only d_req held for 10 accesses, then if_req raised -> streak not advanced by uncontested grants; the next contested arbitration grants D.
- rst=0 during WAIT of a read -> all outputs at reset values next cycle; no ack for that read; after release, a new if_req completes normally.
- ARB_STATS_EN defined, LAT=3, one fetch with no contention -> if_stall_cnt=5 after ack. With the macro undefined, the build has no stats ports.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data (read/write); data wins unless fetch has starved STARVE_LIM contested grants.
// Ack arrives LAT+2 cycles after a request is sampled in IDLE; requesters stall by holding req until ack. ARB_STATS_EN adds stall counters.
module mem_port_arbiter #(
   parameter int unsigned LAT        = 1,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] if_stall_cnt,
   output logic [31:0] d_stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0] LAT_C  = 4'(LAT);
   localparam logic [3:0] SLIM_C = 4'(STARVE_LIM);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  streak_q;
   logic        win_if_q;
   logic        wr_q;
   logic        if_ack_q;
   logic        d_ack_q;
   logic        mem_en_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;
   logic        grant_if_d;

   // Fetch wins when alone, or when it has watched STARVE_LIM contested data grants in a row.
   always_comb begin
      grant_if_d = if_req && (!d_req || (streak_q == SLIM_C));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         streak_q    <= 4'd0;
         win_if_q    <= 1'b0;
         wr_q        <= 1'b0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         d_rdata_q   <= 32'd0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_req || d_req) begin
                  state_q  <= ISSUE;
                  mem_en_q <= 1'b1;
                  win_if_q <= grant_if_d;
                  if (grant_if_d) begin
                     mem_addr_q <= if_addr;
                     wr_q       <= 1'b0;
                     streak_q   <= 4'd0;
                  end else begin
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_we_q    <= d_we;
                     wr_q        <= d_we;
                     if (if_req && (streak_q != SLIM_C)) begin
                        streak_q <= streak_q + 4'd1;
                     end
                  end
               end
            end
            ISSUE: begin
               cnt_q   <= LAT_C;
               state_q <= WAIT;
            end
            WAIT: begin
               // cnt_q==1 is the cycle mem_rdata is valid for the issued read.
               if (cnt_q == 4'd1) begin
                  state_q <= DONE;
                  if (win_if_q) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_rdata;
                  end else begin
                     d_ack_q <= 1'b1;
                     if (!wr_q) begin
                        d_rdata_q <= mem_rdata;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);

`ifdef ARB_STATS_EN
   logic [31:0] if_stall_q;
   logic [31:0] d_stall_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if_stall_q <= 32'd0;
         d_stall_q  <= 32'd0;
      end else begin
         if (if_req && !if_ack_q) begin
            if_stall_q <= if_stall_q + 32'd1;
         end
         if (d_req && !d_ack_q) begin
            d_stall_q <= d_stall_q + 32'd1;
         end
      end
   end

   assign if_stall_cnt = if_stall_q;
   assign d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LAT=2 memory model, queue scoreboard of expected vs acked read data.
module tb_mem_port_arbiter;
   localparam int LAT  = 2;
   localparam int SLIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
`ifdef ARB_STATS_EN
   logic [31:0] if_stall_cnt;
   logic [31:0] d_stall_cnt;
`endif

   int total = 0;
   int bad   = 0;
   int overlap = 0;

   logic [31:0] exp_if[$];
   logic [31:0] exp_d[$];
   logic [31:0] if_obs[$];
   logic [31:0] d_obs[$];
   bit          gnt_log[$];   // 1 = fetch grant, 0 = data grant

   mem_port_arbiter #(.LAT(LAT), .STARVE_LIM(SLIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
      , .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'hA500_0000 | 32'(i);
   endfunction

   // Memory model: writes land at the strobe edge, read data valid LAT cycles after mem_en.
   logic [31:0] mem [0:255];
   logic [31:0] a_pipe [0:LAT-1];
   logic        v_pipe [0:LAT-1];

   always @(posedge clk) begin
      if (!rst && !busy && !mem_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (mem_en && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      a_pipe[0] <= mem_addr;
      v_pipe[0] <= mem_en && !mem_we;
      for (int i = 1; i < LAT; i++) begin
         a_pipe[i] <= a_pipe[i-1];
         v_pipe[i] <= v_pipe[i-1];
      end
   end

   assign mem_rdata = v_pipe[LAT-1] ? mem[a_pipe[LAT-1][9:2]] : 32'hBADBAD00;

   always @(negedge clk) begin
      if (if_ack) if_obs.push_back(if_rdata);
      if (d_ack) d_obs.push_back(d_rdata);
      if (if_ack && d_ack) overlap++;
      if (mem_en) gnt_log.push_back(mem_addr < 32'h100);
   end

   task automatic test_reset;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00000", {if_ack, d_ack, mem_en, mem_we, busy});
      end
      total++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         bad++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
      end
      total++;
      if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
         bad++; $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata, d_rdata);
      end
`ifdef ARB_STATS_EN
      total++;
      if (if_stall_cnt !== 32'd0 || d_stall_cnt !== 32'd0) begin
         bad++; $display("FAIL reset_stats got if=%0d d=%0d want 0", if_stall_cnt, d_stall_cnt);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_fetch;
      exp_if.push_back(32'hDEADBEEF);
      if_req = 1'b1; if_addr = 32'h40;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (mem_en !== (k == 1)) begin
            bad++; $display("FAIL fetch_mem_en cyc=%0d got=%b want=%b", k, mem_en, (k == 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
               bad++; $display("FAIL fetch_mem_addr got=%h we=%b want=00000040 we=0", mem_addr, mem_we);
            end
         end
         total++;
         if (if_ack !== (k == 4) || d_ack !== 1'b0) begin
            bad++; $display("FAIL fetch_ack cyc=%0d got if=%b d=%b want if=%b d=0", k, if_ack, d_ack, (k == 4));
         end
         total++;
         if (busy !== (k >= 1 && k <= 4)) begin
            bad++; $display("FAIL fetch_busy cyc=%0d got=%b want=%b", k, busy, (k >= 1 && k <= 4));
         end
         @(posedge clk); #1;
         if (k == 4) if_req = 1'b0;
      end
`ifdef ARB_STATS_EN
      total++;
      if (if_stall_cnt !== 32'(LAT + 2)) begin
         bad++; $display("FAIL fetch_stall_cnt got=%0d want=%0d", if_stall_cnt, LAT + 2);
      end
`endif
      total++;
      if (if_obs.size() != exp_if.size()) begin
         bad++; $display("FAIL fetch_sb_count got=%0d want=%0d", if_obs.size(), exp_if.size());
      end
      while (exp_if.size() > 0 && if_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_if.pop_front(); o = if_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL fetch_sb_data got=%h want=%h", o, e); end
      end
      exp_if.delete(); if_obs.delete();
   endtask

   task automatic test_write_read;
      int pulses = 0;
      int k_ack = -1;
      exp_d.push_back(32'd0);
      exp_d.push_back(32'h12345678);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (mem_en) pulses++;
         total++;
         if (mem_we !== (k == 1) || mem_en !== (k == 1)) begin
            bad++; $display("FAIL write_strobe cyc=%0d got en=%b we=%b want %b", k, mem_en, mem_we, (k == 1));
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
               bad++; $display("FAIL write_bus got addr=%h data=%h want 00000100/12345678", mem_addr, mem_wdata);
            end
         end
         total++;
         if (d_ack !== (k == 4)) begin
            bad++; $display("FAIL write_ack cyc=%0d got=%b want=%b", k, d_ack, (k == 4));
         end
         @(posedge clk); #1;
         if (k == 1) begin d_we = 1'b0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h1FC; end
         if (k == 4) d_req = 1'b0;
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL write_pulses got=%0d want=1", pulses); end
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (d_ack) begin k_ack = k; @(posedge clk); #1; break; end
         @(posedge clk); #1;
      end
      d_req = 1'b0;
      total++;
      if (k_ack != LAT + 2) begin bad++; $display("FAIL read_latency got=%0d want=%0d", k_ack, LAT + 2); end
      total++;
      if (d_obs.size() != exp_d.size()) begin
         bad++; $display("FAIL wr_sb_count got=%0d want=%0d", d_obs.size(), exp_d.size());
      end
      while (exp_d.size() > 0 && d_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_d.pop_front(); o = d_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL wr_sb_data got=%h want=%h", o, e); end
      end
      exp_d.delete(); d_obs.delete();
   endtask

   task automatic test_back_to_back;
      bit exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int t = 0;
      gnt_log.delete(); overlap = 0;
      for (int i = 0; i < 8; i++) exp_d.push_back(init_word(32'h41));
      for (int i = 0; i < 2; i++) exp_if.push_back(init_word(32'h11));
      if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
      while (gnt_log.size() < 10 && t < 300) begin @(posedge clk); #1; t++; end
      if_req = 1'b0; d_req = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (busy && t < 50);
      @(posedge clk); #1;
      total++;
      if (gnt_log.size() != 10) begin bad++; $display("FAIL b2b_grant_count got=%0d want=10", gnt_log.size()); end
      for (int i = 0; i < 10 && i < gnt_log.size(); i++) begin
         total++;
         if (gnt_log[i] !== exp_g[i]) begin
            bad++; $display("FAIL b2b_grant_order idx=%0d got=%s want=%s", i, gnt_log[i] ? "I" : "D", exp_g[i] ? "I" : "D");
         end
      end
      total++;
      if (overlap != 0) begin bad++; $display("FAIL b2b_ack_overlap got=%0d want=0", overlap); end
      total++;
      if (if_obs.size() != exp_if.size() || d_obs.size() != exp_d.size()) begin
         bad++; $display("FAIL b2b_sb_count got if=%0d d=%0d want if=%0d d=%0d", if_obs.size(), d_obs.size(), exp_if.size(), exp_d.size());
      end
      while (exp_if.size() > 0 && if_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_if.pop_front(); o = if_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL b2b_sb_if got=%h want=%h", o, e); end
      end
      while (exp_d.size() > 0 && d_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_d.pop_front(); o = d_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL b2b_sb_d got=%h want=%h", o, e); end
      end
      exp_if.delete(); if_obs.delete(); exp_d.delete(); d_obs.delete();
   endtask

   task automatic test_uncontested_streak;
      int t = 0;
      gnt_log.delete();
      for (int i = 0; i < 11; i++) exp_d.push_back(init_word(32'h42));
      exp_if.push_back(init_word(32'h12));
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h108;
      while (gnt_log.size() < 10 && t < 300) begin @(posedge clk); #1; t++; end
      if_req = 1'b1; if_addr = 32'h48;
      while (gnt_log.size() < 11 && t < 300) begin @(posedge clk); #1; t++; end
      d_req = 1'b0;
      while (gnt_log.size() < 12 && t < 300) begin @(posedge clk); #1; t++; end
      if_req = 1'b0;
      do begin @(negedge clk); t++; end while (busy && t < 350);
      @(posedge clk); #1;
      total++;
      if (gnt_log.size() != 12) begin bad++; $display("FAIL solo_grant_count got=%0d want=12", gnt_log.size()); end
      if (gnt_log.size() >= 12) begin
         total++;
         if (gnt_log[9] !== 1'b0) begin bad++; $display("FAIL solo_tenth got=I want=D"); end
         total++;
         if (gnt_log[10] !== 1'b0) begin bad++; $display("FAIL solo_first_contested got=I want=D"); end
         total++;
         if (gnt_log[11] !== 1'b1) begin bad++; $display("FAIL solo_fetch_after got=D want=I"); end
      end
      total++;
      if (if_obs.size() != exp_if.size() || d_obs.size() != exp_d.size()) begin
         bad++; $display("FAIL solo_sb_count got if=%0d d=%0d want if=%0d d=%0d", if_obs.size(), d_obs.size(), exp_if.size(), exp_d.size());
      end
      while (exp_d.size() > 0 && d_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_d.pop_front(); o = d_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL solo_sb_d got=%h want=%h", o, e); end
      end
      while (exp_if.size() > 0 && if_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_if.pop_front(); o = if_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL solo_sb_if got=%h want=%h", o, e); end
      end
      exp_if.delete(); if_obs.delete(); exp_d.delete(); d_obs.delete();
   endtask

   task automatic test_reset_mid;
      int k_ack = -1;
      if_req = 1'b1; if_addr = 32'h48;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin
         bad++; $display("FAIL midrst_ctrl got=%b want=00000", {if_ack, d_ack, mem_en, mem_we, busy});
      end
      total++;
      if (if_rdata !== 32'd0 || d_rdata !== 32'd0 || mem_addr !== 32'd0) begin
         bad++; $display("FAIL midrst_data got if=%h d=%h addr=%h want 0", if_rdata, d_rdata, mem_addr);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      total++;
      if (if_obs.size() != 0 || d_obs.size() != 0) begin
         bad++; $display("FAIL midrst_no_ack got if=%0d d=%0d want 0", if_obs.size(), d_obs.size());
      end
      exp_if.push_back(init_word(32'h13));
      if_req = 1'b1; if_addr = 32'h4C;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (if_ack) begin k_ack = k; @(posedge clk); #1; break; end
         @(posedge clk); #1;
      end
      if_req = 1'b0;
      total++;
      if (k_ack != LAT + 2) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", k_ack, LAT + 2); end
      total++;
      if (if_obs.size() != exp_if.size()) begin
         bad++; $display("FAIL midrst_sb_count got=%0d want=%0d", if_obs.size(), exp_if.size());
      end
      while (exp_if.size() > 0 && if_obs.size() > 0) begin
         logic [31:0] e, o;
         e = exp_if.pop_front(); o = if_obs.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL midrst_sb_data got=%h want=%h", o, e); end
      end
      exp_if.delete(); if_obs.delete();
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) begin a_pipe[i] = '0; v_pipe[i] = 1'b0; end
      test_reset();
      test_fetch();
      test_write_read();
      test_back_to_back();
      test_uncontested_streak();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
